// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, error codes and
// timing constants at 32 MHz. The receiver uses the same sample delay
// and timeout values.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SETUP,
    WAIT_FIRST,
    SEND,
    ACK,
    WAIT_IDLE
  } tx_state_t;

  // Error codes reported on err_code alongside tx_error
  localparam logic [1:0] ERR_NONE          = 2'd0;
  localparam logic [1:0] ERR_START_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_FRAME_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_NO_ACK        = 2'd3;

  // Timing at 32 MHz
  localparam int PS2_INHIBIT_CYCLES = 3200;    // 100 us clock inhibit
  localparam int PS2_SETUP_CYCLES   = 32;      // 1 us both lines low
  localparam int PS2_SAMPLE_DELAY   = 10;      // clock debounce
  localparam int PS2_START_TIMEOUT  = 480000;  // 15 ms to first device edge
  localparam int PS2_FRAME_TIMEOUT  = 64000;   // 2 ms to ACK edge

  // Counter widths
  localparam int TIMER_W       = 19;
  localparam int FRAME_TIMER_W = 16;
  localparam int EDGE_W        = 4;

  // Odd parity over a data byte, as carried in the PS/2 frame
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 clock and data pads, debounces the clock and
// produces a one-cycle strobe on each filtered falling edge.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int SAMPLE_DELAY = PS2_SAMPLE_DELAY
) (
  input  logic clk32,
  input  logic rst_n,
  input  logic kbd_clk,
  input  logic kbd_dat,
  output logic clk_filt,
  output logic dat_sync,
  output logic clk_fall
);

  localparam int CNT_W = $clog2(SAMPLE_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DELAY - 1);

  logic clk_meta;
  logic clk_sync;
  logic dat_meta;
  logic [CNT_W-1:0] stable_cnt;

  // Two-flop synchronisers; idle bus level is high on both lines
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= kbd_clk;
      clk_sync <= clk_meta;
      dat_meta <= kbd_dat;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock follows the synced clock only after it has differed for SAMPLE_DELAY cycles in a row
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      clk_filt   <= 1'b1;
      clk_fall   <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (clk_sync == clk_filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        clk_filt   <= clk_sync;
        clk_fall   <= clk_filt;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues the start
// bit, shifts data/parity/stop on device clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int SETUP_CYCLES   = PS2_SETUP_CYCLES,
  parameter int SAMPLE_DELAY   = PS2_SAMPLE_DELAY,
  parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int FRAME_TIMEOUT  = PS2_FRAME_TIMEOUT
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       kbd_dat,
  output logic       kbd_clk_low,
  output logic       kbd_dat_low,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code
);

  localparam logic [TIMER_W-1:0]       INHIBIT_LOAD = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0]       SETUP_LOAD   = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0]       START_LOAD   = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [FRAME_TIMER_W-1:0] FRAME_LOAD   = FRAME_TIMER_W'(FRAME_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0]        EDGE_STOP    = 4'd9;
  localparam logic [EDGE_W-1:0]        EDGE_MAX     = 4'd11;

  logic clk_filt;
  logic dat_sync;
  logic clk_fall;

  tx_state_t                state_q, state_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;
  logic [FRAME_TIMER_W-1:0] frame_timer_q, frame_timer_d;
  logic [EDGE_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic [9:0]               frame_q, frame_d;
  logic                     clk_low_q, clk_low_d;
  logic                     dat_low_q, dat_low_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [1:0]               err_code_q, err_code_d;

  ps2_line_filter #(
    .SAMPLE_DELAY(SAMPLE_DELAY)
  ) u_filter (
    .clk32    (clk32),
    .rst_n    (rst_n),
    .kbd_clk  (kbd_clk),
    .kbd_dat  (kbd_dat),
    .clk_filt (clk_filt),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  // State, timers, shift frame and pad drivers; reset releases both lines at once
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      frame_timer_q <= '0;
      edge_cnt_q    <= '0;
      frame_q       <= '0;
      clk_low_q     <= 1'b0;
      dat_low_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      frame_timer_q <= frame_timer_d;
      edge_cnt_q    <= edge_cnt_d;
      frame_q       <= frame_d;
      clk_low_q     <= clk_low_d;
      dat_low_q     <= dat_low_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_code_q    <= err_code_d;
    end
  end

  // Next-state logic; the wait for the first device edge is bounded by the start timeout
  // alone, while the frame timer already counts so the frame budget runs from clock release
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    frame_timer_d = frame_timer_q;
    edge_cnt_d    = edge_cnt_q;
    frame_d       = frame_q;
    clk_low_d     = clk_low_q;
    dat_low_d     = dat_low_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    err_code_d    = err_code_q;

    if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
    if ((frame_timer_q != '0) &&
        ((state_q == WAIT_FIRST) || (state_q == SEND) || (state_q == ACK))) begin
      frame_timer_d = frame_timer_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        if (tx_valid) begin
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          timer_d   = INHIBIT_LOAD;
          clk_low_d = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (timer_q == '0) begin
          dat_low_d = 1'b1;
          timer_d   = SETUP_LOAD;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (timer_q == '0) begin
          clk_low_d     = 1'b0;
          timer_d       = START_LOAD;
          frame_timer_d = FRAME_LOAD;
          edge_cnt_d    = '0;
          state_d       = WAIT_FIRST;
        end
      end

      WAIT_FIRST: begin
        if (timer_q == '0) begin
          clk_low_d  = 1'b0;
          dat_low_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_START_TIMEOUT;
          state_d    = IDLE;
        end else if (clk_fall) begin
          dat_low_d  = ~frame_q[0];
          edge_cnt_d = 4'd1;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (frame_timer_q == '0) begin
          clk_low_d  = 1'b0;
          dat_low_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_FRAME_TIMEOUT;
          state_d    = IDLE;
        end else if (clk_fall) begin
          dat_low_d  = ~frame_q[edge_cnt_q];
          edge_cnt_d = (edge_cnt_q == EDGE_MAX) ? EDGE_MAX : edge_cnt_q + 1'b1;
          if (edge_cnt_q == EDGE_STOP) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        if (frame_timer_q == '0) begin
          clk_low_d  = 1'b0;
          dat_low_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_FRAME_TIMEOUT;
          state_d    = IDLE;
        end else if (clk_fall) begin
          edge_cnt_d = (edge_cnt_q == EDGE_MAX) ? EDGE_MAX : edge_cnt_q + 1'b1;
          if (!dat_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            clk_low_d  = 1'b0;
            dat_low_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_NO_ACK;
            state_d    = IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_filt && dat_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign kbd_clk_low = clk_low_q;
  assign kbd_dat_low = dat_low_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a scaled-down PS/2 device model.
module tb_ps2_host_tx;

  localparam int INHIBIT  = 200;
  localparam int SETUPC   = 32;
  localparam int SDLY     = 10;
  localparam int START_TO = 3000;
  localparam int FRAME_TO = 2500;
  localparam int H        = 100;
  localparam int D        = 50;

  logic       clk32 = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_pad;
  logic       dat_pad;
  logic       kbd_clk_low;
  logic       kbd_dat_low;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         err_cyc = 0;
  logic [1:0] err_seen = 2'd0;
  bit         track = 1'b0;
  int         busy_drop = 0;
  int         rel_cyc = 0;

  assign clk_pad = dev_clk & ~kbd_clk_low;
  assign dat_pad = dev_dat & ~kbd_dat_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .SETUP_CYCLES  (SETUPC),
    .SAMPLE_DELAY  (SDLY),
    .START_TIMEOUT (START_TO),
    .FRAME_TIMEOUT (FRAME_TO)
  ) dut (
    .clk32       (clk32),
    .rst_n       (rst_n),
    .kbd_clk     (clk_pad),
    .kbd_dat     (dat_pad),
    .kbd_clk_low (kbd_clk_low),
    .kbd_dat_low (kbd_dat_low),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .err_code    (err_code)
  );

  always #5 clk32 = ~clk32;

  // Cycle counter and pulse monitor, sampled shortly after each rising edge
  always @(posedge clk32) begin
    cyc++;
    #2;
    if (tx_done) begin
      done_cnt++;
      track = 1'b0;
    end else if (track && !busy) begin
      busy_drop++;
    end
    if (tx_error) begin
      err_cnt++;
      err_cyc  = cyc;
      err_seen = err_code;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      $error("[TB] assertion on %s", tag);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk32);
    tx_valid = 1'b1;
    tx_data  = data;
    @(negedge clk32);
    tx_valid = 1'b0;
  endtask

  // Device side: observe the request, then clock nfalls edges and optionally ACK
  task automatic deviceRun(input int nfalls, input bit ack_low, input bit glitch,
                           output logic [9:0] bits, output int inh, output int stp,
                           output logic start_lvl, output logic got_req);
    bits = '0;
    inh = 0;
    stp = 0;
    start_lvl = 1'b1;
    got_req = 1'b0;
    for (int i = 0; i < 1000 && !kbd_clk_low; i++) @(negedge clk32);
    while (kbd_clk_low && !kbd_dat_low && inh < 20000) begin
      inh++;
      @(negedge clk32);
    end
    while (kbd_clk_low && kbd_dat_low && stp < 20000) begin
      stp++;
      @(negedge clk32);
    end
    if (kbd_clk_low || !kbd_dat_low) return;
    got_req = 1'b1;
    rel_cyc = cyc;
    start_lvl = dat_pad;
    repeat (D) @(negedge clk32);
    for (int k = 0; k < nfalls && k < 10; k++) begin
      dev_clk = 1'b0;
      if (glitch) begin
        repeat (H/2) @(negedge clk32);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk32);
        dev_clk = 1'b0;
        repeat (H/2 - 2) @(negedge clk32);
      end else begin
        repeat (H) @(negedge clk32);
      end
      bits[k] = dat_pad;
      dev_clk = 1'b1;
      if (glitch) begin
        repeat (H/2) @(negedge clk32);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk32);
        dev_clk = 1'b1;
        repeat (H/2 - 2) @(negedge clk32);
      end else begin
        repeat (H) @(negedge clk32);
      end
    end
    if (nfalls > 10) begin
      dev_dat = ack_low ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk32);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk32);
      dev_dat = 1'b1;
    end
  endtask

  task automatic waitEvent(input int budget, input int done0, input int err0);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != done0 || err_cnt != err0) break;
      @(negedge clk32);
    end
    repeat (20) @(negedge clk32);
  endtask

  initial begin
    logic [9:0] bits;
    int         inh;
    int         stp;
    logic       start_lvl;
    logic       got;
    int         d0;
    int         e0;

    // Reset state
    repeat (3) @(negedge clk32);
    checkOutput("rst_clk_low", kbd_clk_low, 0);
    checkOutput("rst_dat_low", kbd_dat_low, 0);
    checkOutput("rst_done", tx_done, 0);
    checkOutput("rst_error", tx_error, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk32);

    // 0xED with ACK
    $display("[TB] send 0xED");
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(8'hED);
    checkOutput("ed_ready_low", tx_ready, 0);
    checkOutput("ed_busy", busy, 1);
    deviceRun(11, 1'b1, 1'b0, bits, inh, stp, start_lvl, got);
    checkOutput("ed_request", got, 1);
    checkOutput("ed_inhibit_len", inh, INHIBIT);
    checkOutput("ed_setup_len", stp, SETUPC);
    checkOutput("ed_start_bit", start_lvl, 0);
    checkOutput("ed_bits", bits, 10'h3ED);
    waitEvent(500, d0, e0);
    checkOutput("ed_done_once", done_cnt - d0, 1);
    checkOutput("ed_no_error", err_cnt - e0, 0);
    checkOutput("ed_err_code", err_code, 0);
    checkOutput("ed_ready_after", tx_ready, 1);

    // 0xF4 with busy tracking
    $display("[TB] send 0xF4");
    d0 = done_cnt; e0 = err_cnt; busy_drop = 0;
    applyStimulus(8'hF4);
    track = 1'b1;
    deviceRun(11, 1'b1, 1'b0, bits, inh, stp, start_lvl, got);
    checkOutput("f4_bits", bits, 10'h2F4);
    checkOutput("f4_parity", bits[8], 0);
    waitEvent(500, d0, e0);
    checkOutput("f4_done_once", done_cnt - d0, 1);
    checkOutput("f4_busy_held", busy_drop, 0);
    checkOutput("f4_busy_after", busy, 0);

    // Device never clocks
    $display("[TB] start timeout");
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(8'h12);
    deviceRun(0, 1'b1, 1'b0, bits, inh, stp, start_lvl, got);
    checkOutput("st_request", got, 1);
    waitEvent(START_TO + 200, d0, e0);
    checkOutput("st_error_once", err_cnt - e0, 1);
    checkOutput("st_code_pulse", err_seen, 1);
    checkOutput("st_code_hold", err_code, 1);
    checkOutput("st_delay", err_cyc - rel_cyc, START_TO);
    checkOutput("st_clk_low", kbd_clk_low, 0);
    checkOutput("st_dat_low", kbd_dat_low, 0);
    checkOutput("st_no_done", done_cnt - d0, 0);

    // Device stops after 5 falls
    $display("[TB] frame timeout");
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(8'h34);
    deviceRun(5, 1'b1, 1'b0, bits, inh, stp, start_lvl, got);
    waitEvent(FRAME_TO + 200, d0, e0);
    checkOutput("ft_error_once", err_cnt - e0, 1);
    checkOutput("ft_code", err_seen, 2);
    checkOutput("ft_delay", err_cyc - rel_cyc, FRAME_TO);
    checkOutput("ft_lines", {kbd_clk_low, kbd_dat_low}, 0);

    // No ACK
    $display("[TB] missing ack");
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(8'h56);
    deviceRun(11, 1'b0, 1'b0, bits, inh, stp, start_lvl, got);
    checkOutput("na_bits", bits, 10'h356);
    waitEvent(500, d0, e0);
    checkOutput("na_error_once", err_cnt - e0, 1);
    checkOutput("na_code", err_seen, 3);
    checkOutput("na_no_done", done_cnt - d0, 0);

    // Asynchronous reset in the middle of SEND
    $display("[TB] reset during send");
    applyStimulus(8'hED);
    deviceRun(2, 1'b1, 1'b0, bits, inh, stp, start_lvl, got);
    checkOutput("rs_dat_low_pre", kbd_dat_low, 1);
    checkOutput("rs_busy_pre", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rs_clk_low", kbd_clk_low, 0);
    checkOutput("rs_dat_low", kbd_dat_low, 0);
    checkOutput("rs_ready", tx_ready, 1);
    @(negedge clk32);
    rst_n = 1'b1;
    repeat (5) @(negedge clk32);
    checkOutput("rs_err_code", err_code, 0);
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(8'hFF);
    deviceRun(11, 1'b1, 1'b0, bits, inh, stp, start_lvl, got);
    checkOutput("ff_bits", bits, 10'h3FF);
    waitEvent(500, d0, e0);
    checkOutput("ff_done_once", done_cnt - d0, 1);

    // Clock glitches during SEND
    $display("[TB] glitched clock");
    d0 = done_cnt; e0 = err_cnt;
    applyStimulus(8'h5B);
    deviceRun(11, 1'b1, 1'b1, bits, inh, stp, start_lvl, got);
    checkOutput("gl_bits", bits, 10'h25B);
    waitEvent(500, d0, e0);
    checkOutput("gl_done_once", done_cnt - d0, 1);
    checkOutput("gl_no_error", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable.
- Runs the full host request sequence: clock inhibit, start bit, data/parity/stop bits on device-generated clock, then checks the device ACK.
- Drives the open-drain kbd_clk/kbd_dat pads through active-high pull-low enables.
- Exports busy so the PS/2 receiver on the same lines can be gated while a transmit is in progress.

Parameters:
- INHIBIT_CYCLES, 3200: clock-low inhibit time (100 us at 32 MHz).
- SETUP_CYCLES, 32: both lines held low before clock release (1 us).
- SAMPLE_DELAY, 10: clock debounce; filtered clock follows raw clock only after this many stable cycles.
- START_TIMEOUT, 480000: max cycles from clock release to first device falling edge (15 ms).
- FRAME_TIMEOUT, 64000: max cycles from clock release to ACK edge (2 ms).

Ports:
- clk32  in  1  system clock, 32 MHz
- rst_n  in  1  asynchronous active-low reset
- kbd_clk  in  1  raw PS/2 clock pad level
- kbd_dat  in  1  raw PS/2 data pad level
- kbd_clk_low  out  1  1 = pull clock pad low, 0 = release
- kbd_dat_low  out  1  1 = pull data pad low, 0 = release
- tx_valid  in  1  command byte request
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in any state other than IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACK received
- tx_error  out  1  one-cycle pulse: transfer aborted
- err_code  out  2  valid with tx_error: 1 = start timeout, 2 = frame timeout, 3 = no ACK; holds until next error

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; both pull-lows 0 (lines released immediately, including mid-transfer).
  - tx_done=0, tx_error=0, err_code=0; filtered clock=1.
- Input path:
  - kbd_clk and kbd_dat pass through 2-flop synchronisers.
  - Filtered clock updates only after the synced clock is stable for SAMPLE_DELAY cycles.
  - fall = filtered clock 1->0, registered as a one-cycle strobe.
- Accept: tx_valid & tx_ready on the same edge latches tx_data and parity = ~^tx_data (odd parity).
  - Shift frame is {1'b1 stop, parity, data}, 10 bits, LSB first.
  - tx_valid is ignored while not ready.
- States:
  - IDLE: lines released. On accept, go to INHIBIT, load timer = INHIBIT_CYCLES-1.
  - INHIBIT: kbd_clk_low=1. At timer 0, set kbd_dat_low=1 (start bit), load SETUP_CYCLES-1, go to SETUP.
  - SETUP: both lines low. At timer 0, release clock, load start and frame timers, set edge count=0, go to WAIT_FIRST.
  - WAIT_FIRST: data held low. First fall drives frame bit 0, edge count=1, go to SEND. Start timer expiry -> error 1.
  - SEND: on each fall, kbd_dat_low = ~frame[edge count], then count++.
    - Falls 1-8 drive d0-d7, fall 9 drives parity, fall 10 drives stop (release).
    - After fall 10, go to ACK.
  - ACK: on fall 11, sample synced kbd_dat. 0 -> WAIT_IDLE; 1 -> error 3.
  - WAIT_IDLE: wait until filtered clock=1 and synced data=1, then pulse tx_done, go to IDLE.
  - Frame timer runs through WAIT_FIRST, SEND and ACK; expiry -> error 2.
- Error path: release both lines that cycle, pulse tx_error, set err_code, go to IDLE.
  - If start and frame timeouts expire in the same cycle, the start timeout wins.
- Timing: data changes within SAMPLE_DELAY+4 cycles of the raw falling edge, well inside the device's low half-period.
- Widths:
  - One shared 19-bit down-timer for inhibit/setup/start.
  - Separate 16-bit frame timer.
  - 4-bit edge counter, saturating at 11.
- tx_ready deasserts the cycle after accept. A back-to-back request is accepted in the cycle following the tx_done/tx_error pulse.

Decomposition:
- ps2_pkg:
  - state enum (IDLE, INHIBIT, SETUP, WAIT_FIRST, SEND, ACK, WAIT_IDLE).
  - err_code localparams.
  - timing constants at 32 MHz, shared with the receiver's timeout and sample-delay values.
- Sub-module ps2_line_filter: synchroniser + SAMPLE_DELAY debounce + fall strobe. Reusable by the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - clock low ≥3200 cycles, then start bit.
  - bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once, err_code unchanged.
- Send 0xF4: parity 0 seen on fall 9; busy high from accept until tx_done.
- Device never clocks: tx_error with err_code=1 exactly 480000 cycles after clock release; both pull-lows 0.
- Device stops after 5 falls: tx_error with err_code=2 at 64000 cycles after clock release.
- Device leaves data high on fall 11: tx_error with err_code=3, no tx_done.
- rst_n low during SEND: kbd_clk_low=0 and kbd_dat_low=0 immediately (asynchronous). After release, tx_ready=1 and a new 0xFF transfer completes.
- 2-cycle glitches on kbd_clk during SEND produce no extra bits; data still matches.
